// File: rtl/limbus_sys_acortex_st_unpack_adaptor.sv
// rtl/limbus_sys_acortex_st_unpack_adaptor.sv - unpacks multi-symbol stream beats into one symbol per cycle
// A single registered holding buffer feeds the output mux; a new beat reloads it on the last-symbol handoff.
module limbus_sys_acortex_st_unpack_adaptor #(
  localparam int SYMBOL_WIDTH = 8,
  localparam int IN_SYMBOLS   = 2,
  localparam int EMPTY_WIDTH  = 1,
  localparam int DATA_W       = SYMBOL_WIDTH * IN_SYMBOLS,
  localparam int SEL_W        = (IN_SYMBOLS > 1) ? $clog2(IN_SYMBOLS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_startofpacket,
  input  logic                    in_endofpacket,
  input  logic [EMPTY_WIDTH-1:0]  in_empty,
  output logic [SYMBOL_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_startofpacket,
  output logic                    out_endofpacket
);

  localparam logic [SEL_W-1:0] LAST_FULL = SEL_W'(IN_SYMBOLS - 1);

  logic [DATA_W-1:0]       r_data;
  logic                    r_sop;
  logic                    r_eop;
  logic [SEL_W-1:0]        r_last_idx;
  logic                    r_full;
  logic [SEL_W-1:0]        r_sel;
  logic                    r_ready_en;

  logic                    w_out_xfer;
  logic                    w_at_last;
  logic                    w_in_xfer;
  logic [SEL_W-1:0]        w_last_idx_in;
  logic [SYMBOL_WIDTH-1:0] w_sym;

  assign w_out_xfer = r_full && out_ready;
  assign w_at_last  = (r_sel == r_last_idx);
  assign in_ready   = r_ready_en && (!r_full || (w_out_xfer && w_at_last));
  assign w_in_xfer  = in_valid && in_ready;

  // in_empty only means something on the closing beat of a packet
  assign w_last_idx_in = in_endofpacket ? (LAST_FULL - SEL_W'(in_empty)) : LAST_FULL;

  // Symbol 0 lives in the most significant lane
  always_comb begin
    w_sym = '0;
    for (int i = 0; i < IN_SYMBOLS; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_sym = r_data[(IN_SYMBOLS-1-i)*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      end
    end
  end

  assign out_data          = w_sym;
  assign out_valid         = r_full;
  assign out_startofpacket = r_full && r_sop && (r_sel == '0);
  assign out_endofpacket   = r_full && r_eop && w_at_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= '0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_last_idx <= '0;
      r_full     <= 1'b0;
      r_sel      <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_in_xfer) begin
        r_data     <= in_data;
        r_sop      <= in_startofpacket;
        r_eop      <= in_endofpacket;
        r_last_idx <= w_last_idx_in;
        r_full     <= 1'b1;
        r_sel      <= '0;
      end else if (w_out_xfer) begin
        if (w_at_last) begin
          r_sel  <= '0;
          r_full <= 1'b0;
        end else begin
          r_sel  <= r_sel + SEL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_limbus_sys_acortex_st_unpack_adaptor.sv
// tb/tb_limbus_sys_acortex_st_unpack_adaptor.sv - directed and scoreboarded checks of the unpack adaptor
module tb_limbus_sys_acortex_st_unpack_adaptor;

  logic        clk;
  logic        reset_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [0:0]  in_empty;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_startofpacket;
  logic        out_endofpacket;

  int total = 0;
  int bad   = 0;

  logic [15:0] bd   [$];
  logic        bsop [$];
  logic        beop [$];
  logic        bemp [$];
  logic [9:0]  expq [$];

  limbus_sys_acortex_st_unpack_adaptor dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_beat(input logic [15:0] d, input logic s, input logic e, input logic m);
    bd.push_back(d);
    bsop.push_back(s);
    beop.push_back(e);
    bemp.push_back(m);
  endtask

  // Drives the queued beats and checks output against a symbol-level scoreboard
  task automatic run_stream(input bit bp);
    int n;
    int b;
    int cyc;
    bit started;
    bit stalled;
    logic [7:0] held;
    logic [9:0] e;
    int li;
    n = bd.size();
    b = 0;
    cyc = 0;
    started = 0;
    stalled = 0;
    held = '0;
    expq.delete();
    for (int i = 0; i < n; i++) begin
      li = beop[i] ? (1 - int'(bemp[i])) : 1;
      for (int s = 0; s <= li; s++) begin
        expq.push_back({bsop[i] && (s == 0), beop[i] && (s == li),
                        (s == 0) ? bd[i][15:8] : bd[i][7:0]});
      end
    end
    while ((b < n || expq.size() > 0) && cyc < 4000) begin
      tick();
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      in_valid  = (b < n) && (bp ? ($urandom_range(3) != 0) : 1'b1);
      if (b < n) begin
        in_data          = bd[b];
        in_startofpacket = bsop[b];
        in_endofpacket   = beop[b];
        in_empty         = bemp[b];
      end
      #1;
      if (out_valid) begin
        if (stalled) check("hold", {24'h0, out_data}, {24'h0, held});
        if (out_ready) begin
          if (expq.size() == 0) begin
            check("extra_sym", 32'd1, 32'd0);
          end else begin
            e = expq.pop_front();
            check("sym", {22'h0, out_startofpacket, out_endofpacket, out_data}, {22'h0, e});
          end
          started = 1;
        end
        stalled = !out_ready;
        held    = out_data;
      end else begin
        stalled = 0;
        if (!bp && started && expq.size() > 0) check("bubble", 32'd0, 32'd1);
      end
      if (!bp && b < n) check("in_ready_alt", {31'h0, in_ready}, {31'h0, (cyc % 2 == 0)});
      if (in_valid && in_ready) b++;
      cyc++;
    end
    check("stream_done", expq.size() + (n - b), 32'd0);
    in_valid = 1'b0;
    tick();
    check("stream_idle", {31'h0, out_valid}, 32'd0);
    bd.delete();
    bsop.delete();
    beop.delete();
    bemp.delete();
  endtask

  initial begin
    reset_n          = 1'b0;
    in_data          = '0;
    in_valid         = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    in_empty         = '0;
    out_ready        = 1'b0;

    tick();
    tick();
    check("rst_in_ready", {31'h0, in_ready}, 32'd0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    check("rst_sop_eop", {30'h0, out_startofpacket, out_endofpacket}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready_early", {31'h0, in_ready}, 32'd0);
    tick();
    check("rel_in_ready", {31'h0, in_ready}, 32'd1);

    // Single full beat
    out_ready = 1'b1;
    in_data = 16'hA55A; in_startofpacket = 1'b1; in_endofpacket = 1'b1; in_empty = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("single_c1", {22'h0, out_valid, out_startofpacket, out_endofpacket, out_data}, {22'h0, 3'b110, 8'hA5});
    tick();
    check("single_c2", {22'h0, out_valid, out_startofpacket, out_endofpacket, out_data}, {22'h0, 3'b101, 8'h5A});
    tick();
    check("single_done", {31'h0, out_valid}, 32'd0);

    // One-symbol packet via in_empty
    in_data = 16'h3C00; in_empty = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("empty_sym", {22'h0, out_valid, out_startofpacket, out_endofpacket, out_data}, {22'h0, 3'b111, 8'h3C});
    tick();
    check("empty_done", {31'h0, out_valid}, 32'd0);
    check("empty_in_ready", {31'h0, in_ready}, 32'd1);

    // Full throughput
    add_beat(16'h0102, 1'b1, 1'b0, 1'b0);
    add_beat(16'h0304, 1'b0, 1'b0, 1'b0);
    add_beat(16'h0506, 1'b0, 1'b0, 1'b0);
    add_beat(16'h0708, 1'b0, 1'b1, 1'b0);
    run_stream(1'b0);

    // in_empty without eop is ignored
    add_beat(16'h1234, 1'b1, 1'b0, 1'b1);
    add_beat(16'h5678, 1'b0, 1'b1, 1'b0);
    run_stream(1'b0);

    // Random stream under backpressure
    for (int i = 0; i < 200; i++) begin
      logic eop_r;
      eop_r = ($urandom_range(3) == 0);
      add_beat(16'($urandom), ($urandom_range(3) == 0), eop_r, 1'($urandom_range(1)));
    end
    run_stream(1'b1);

    // Reset in the middle of a beat
    out_ready = 1'b1;
    in_data = 16'hBEEF; in_startofpacket = 1'b1; in_endofpacket = 1'b1; in_empty = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("mid_sym0", {24'h0, out_data}, 32'hBE);
    tick();
    check("mid_sym1_pending", {23'h0, out_valid, out_data}, {23'h0, 1'b1, 8'hEF});
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_no_ef", {31'h0, out_valid}, 32'd0);
    end
    check("mid_in_ready", {31'h0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/limbus_sys_acortex_st_unpack_adaptor.md
LIMBUS_SYS_ACORTEX_ST_UNPACK_ADAPTOR -- requirements
Module: limbus_sys_acortex_st_unpack_adaptor

Interface
REQ-001 Localparam SYMBOL_WIDTH, default 8, SHALL set the bit width of one symbol.
REQ-002 Localparam IN_SYMBOLS, default 2, SHALL set the number of symbols per input beat.
REQ-003 Localparam EMPTY_WIDTH, default 1, SHALL set the in_empty width.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Port in_data, input, 16, SHALL carry the input beat; symbol 0 is bits 15:8 and symbol 1 is bits 7:0.
REQ-007 Port in_valid, input, 1, SHALL qualify an input beat.
REQ-008 Port in_ready, output, 1, SHALL accept an input beat when high together with in_valid.
REQ-009 Port in_startofpacket, input, 1, SHALL mark the first beat of a packet.
REQ-010 Port in_endofpacket, input, 1, SHALL mark the last beat of a packet.
REQ-011 Port in_empty, input, 1, SHALL give the count of unused trailing symbols; it is valid only with in_endofpacket.
REQ-012 Port out_data, output, 8, SHALL carry one symbol.
REQ-013 Port out_valid, output, 1, SHALL qualify out_data and the out_* markers.
REQ-014 Port out_ready, input, 1, SHALL indicate that the sink accepts the current output symbol.
REQ-015 Port out_startofpacket, output, 1, SHALL mark the first output symbol of a packet.
REQ-016 Port out_endofpacket, output, 1, SHALL mark the last output symbol of a packet.

Function
REQ-017 An input transfer SHALL occur when in_valid and in_ready are both high at a rising clk edge.
REQ-018 An output transfer SHALL occur when out_valid and out_ready are both high at a rising clk edge.
REQ-019 The block SHALL hold one input beat in a registered holding buffer with these fields:
  - data[15:0], sop, eop, last_idx;
  - full flag;
  - 1-bit symbol select sel.
REQ-020 last_idx SHALL be captured on an accepted beat as (IN_SYMBOLS-1) - in_empty when in_endofpacket=1, else IN_SYMBOLS-1.
REQ-021 Buffer states:
  - EMPTY (full=0): out_valid=0.
  - HOLD (full=1): out_valid=1, out_data = the symbol selected by sel.
REQ-022 out_startofpacket SHALL equal buffer sop && sel==0.
REQ-023 out_endofpacket SHALL equal buffer eop && sel==last_idx.
REQ-024 On an output transfer with sel<last_idx: sel SHALL increment by 1, and full SHALL stay 1.
REQ-025 On an output transfer with sel==last_idx: sel SHALL return to 0, and full SHALL clear unless a new beat is accepted in the same cycle.
REQ-026 in_ready SHALL be combinational: ready_en && (!full || (out_valid && out_ready && sel==last_idx)).
REQ-027 A simultaneous last-symbol output and input accept SHALL load the new beat with no bubble, giving one symbol per clk at full throughput.
REQ-028 Latency SHALL be 1 cycle: a beat accepted at edge n SHALL present symbol 0 with out_valid=1 after edge n.
REQ-029 out_data, out_valid, out_startofpacket and out_endofpacket SHALL be driven from registers and buffer muxing only; there SHALL be no combinational in_* to out_* path.
REQ-030 The block SHALL NOT check sop/eop framing; an sop beat arriving without a preceding eop SHALL pass through unchanged.
REQ-031 in_empty=1 with in_endofpacket=0 SHALL be ignored, and last_idx SHALL be 1.
REQ-032 out_data SHALL hold its value while out_valid=1 and out_ready=0.

Reset
REQ-033 While reset_n=0, the following SHALL hold:
  - full=0, sel=0, buffer sop/eop=0, data=0, ready_en=0;
  - hence out_valid=0, out_startofpacket=0, out_endofpacket=0, out_data=0x00, in_ready=0.
REQ-034 ready_en SHALL set on the first rising clk edge after reset_n deasserts, so in_ready is first able to rise one cycle after release.
REQ-035 Reset asserted mid-packet SHALL discard the held beat immediately; no partial symbol SHALL be emitted after release.

Verification
REQ-036 Reset: hold reset_n=0 for 2 clks -> in_ready=0, out_valid=0; one clk after release -> in_ready=1.
REQ-037 Single beat: in_data=0xA55A with sop=1, eop=1, empty=0, out_ready=1 ->
  - cycle 1: out_data=0xA5, sop=1;
  - cycle 2: out_data=0x5A, eop=1;
  - then out_valid=0.
REQ-038 Empty symbol: in_data=0x3C00 with sop=1, eop=1, empty=1 -> one symbol 0x3C with out_startofpacket=1 and out_endofpacket=1; in_ready=1 in the next cycle.
REQ-039 Throughput: 4 back-to-back beats 0x0102, 0x0304, 0x0506, 0x0708 (sop on the first, eop on the last), out_ready=1 -> 8 consecutive symbols 01..08 with no bubble; in_ready=0 on every second cycle.
REQ-040 Backpressure: out_ready pattern 1,0,0,1,... against a random stream -> out_data stable while stalled, no symbol lost or duplicated, and output matches a scoreboard of 200 random beats.
REQ-041 Mid-packet reset: assert reset_n=0 after symbol 0 of beat 0xBEEF is transferred -> out_valid=0 at once; after release, 0xEF is never emitted.
